rfile_wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the 16-entry register file. It shares the register file's single write port (`cadr`, `c`, `rfile_we`) between the ALU write-back stage and the load unit, using round-robin arbitration with valid/ready handshakes. Commits go through one registered output stage. An optional pending-write scoreboard reports read-after-write and write-after-write hazards to the issue stage.

---
 rtl/rfile_wb_arbiter_pkg.sv | 21 ++
 rtl/rfile_wb_arbiter_scoreboard.sv | 45 ++++
 rtl/rfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_rfile_wb_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfile_wb_arbiter_pkg.sv
// Shared constants and encodings for the register-file write-back arbiter.
// Constant values mirror the def.h register width and address width.
package rfile_wb_arbiter_pkg;

    localparam int DEF_REG_W    = 16;
    localparam int DEF_OPRAND_W = 4;
    localparam int DEF_NREG     = 2 ** DEF_OPRAND_W;

    // What the registered output stage is driving this cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_ALU = 2'd1,
        WR_LD  = 2'd2
    } wb_state_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/rfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard (module rfile_scoreboard), only built when
// RFILE_WB_SCOREBOARD_EN is defined; one pend bit per register.
`ifdef RFILE_WB_SCOREBOARD_EN
module rfile_scoreboard #(
    parameter int OPRAND_W = 4,
    parameter int NREG     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [OPRAND_W-1:0] issue_adr,
    input  logic                commit,
    input  logic [OPRAND_W-1:0] commit_adr,
    input  logic [OPRAND_W-1:0] chk_aadr,
    input  logic [OPRAND_W-1:0] chk_badr,
    input  logic [OPRAND_W-1:0] chk_cadr,
    output logic                hazard
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Clear is applied before set so a same-cycle issue to the committing register keeps it pending
    always_comb begin
        pend_d = pend_q;
        if (commit) begin
            pend_d[commit_adr] = 1'b0;
        end
        if (issue_valid) begin
            pend_d[issue_adr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign hazard = pend_q[chk_aadr] | pend_q[chk_badr] | pend_q[chk_cadr];

endmodule
`endif

// File: rtl/rfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load unit.
// Optional pending-write scoreboard enabled by defining RFILE_WB_SCOREBOARD_EN.
module rfile_wb_arbiter #(
    parameter int REG_W    = rfile_wb_arbiter_pkg::DEF_REG_W,
    parameter int OPRAND_W = rfile_wb_arbiter_pkg::DEF_OPRAND_W,
    parameter int NREG     = rfile_wb_arbiter_pkg::DEF_NREG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [OPRAND_W-1:0] alu_adr,
    input  logic [REG_W-1:0]    alu_data,
    output logic                alu_ready,
    input  logic                ld_valid,
    input  logic [OPRAND_W-1:0] ld_adr,
    input  logic [REG_W-1:0]    ld_data,
    output logic                ld_ready,
    input  logic                wb_hold,
    output logic [OPRAND_W-1:0] cadr,
    output logic [REG_W-1:0]    c,
    output logic                rfile_we,
    input  logic                issue_valid,
    input  logic [OPRAND_W-1:0] issue_adr,
    input  logic [OPRAND_W-1:0] chk_aadr,
    input  logic [OPRAND_W-1:0] chk_badr,
    input  logic [OPRAND_W-1:0] chk_cadr,
    output logic                hazard
);

    import rfile_wb_arbiter_pkg::*;

    wb_state_e state_q, state_d;
    wb_src_e   last_grant_q;
    logic      grant_alu;
    logic      grant_ld;

    // Grant is only issued to a valid requester, so a grant is a completed handshake
    always_comb begin
        grant_alu = 1'b0;
        grant_ld  = 1'b0;
        state_d   = IDLE;
        if (!rst && !wb_hold) begin
            if (alu_valid && ld_valid) begin
                if (last_grant_q == SRC_LD) begin
                    grant_alu = 1'b1;
                end else begin
                    grant_ld = 1'b1;
                end
            end else if (alu_valid) begin
                grant_alu = 1'b1;
            end else if (ld_valid) begin
                grant_ld = 1'b1;
            end
        end
        if (grant_alu) begin
            state_d = WR_ALU;
        end else if (grant_ld) begin
            state_d = WR_LD;
        end
    end

    assign alu_ready = grant_alu;
    assign ld_ready  = grant_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_LD;
            cadr         <= '0;
            c            <= '0;
        end else begin
            state_q <= state_d;
            if (grant_alu) begin
                cadr         <= alu_adr;
                c            <= alu_data;
                last_grant_q <= SRC_ALU;
            end else if (grant_ld) begin
                cadr         <= ld_adr;
                c            <= ld_data;
                last_grant_q <= SRC_LD;
            end
        end
    end

    // Write enable is a pure decode of the state register
    assign rfile_we = (state_q != IDLE);

`ifdef RFILE_WB_SCOREBOARD_EN
    rfile_scoreboard #(
        .OPRAND_W (OPRAND_W),
        .NREG     (NREG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_adr   (issue_adr),
        .commit      (rfile_we),
        .commit_adr  (cadr),
        .chk_aadr    (chk_aadr),
        .chk_badr    (chk_badr),
        .chk_cadr    (chk_cadr),
        .hazard      (hazard)
    );
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_adr, chk_aadr, chk_badr, chk_cadr};
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_rfile_wb_arbiter.sv
// Self-checking bench for rfile_wb_arbiter: expected commits are queued when a
// handshake is driven and popped by a monitor when the output stage updates.
module tb_rfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_adr;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [3:0]  ld_adr;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        wb_hold;
    logic [3:0]  cadr;
    logic [15:0] c;
    logic        rfile_we;
    logic        issue_valid;
    logic [3:0]  issue_adr;
    logic [3:0]  chk_aadr;
    logic [3:0]  chk_badr;
    logic [3:0]  chk_cadr;
    logic        hazard;

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic        mon_en   = 1'b0;
    logic        rf_clear = 1'b1;
    logic [15:0] rf [16];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    rfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_adr     (alu_adr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .ld_valid    (ld_valid),
        .ld_adr      (ld_adr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .wb_hold     (wb_hold),
        .cadr        (cadr),
        .c           (c),
        .rfile_we    (rfile_we),
        .issue_valid (issue_valid),
        .issue_adr   (issue_adr),
        .chk_aadr    (chk_aadr),
        .chk_badr    (chk_badr),
        .chk_cadr    (chk_cadr),
        .hazard      (hazard)
    );

    always #5 clk = ~clk;

    // Register file driven by the arbiter's write port
    always @(posedge clk or posedge rf_clear) begin
        if (rf_clear) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
        end else if (rfile_we) begin
            rf[cadr] <= c;
        end
    end

    // Commit monitor: one expected entry per enabled cycle
    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL commit_underflow: got rfile_we=%0b with no expected entry", rfile_we);
            end else begin
                mon_e = exp_q.pop_front();
                if (rfile_we !== mon_e.we)
                    $display("[TB] FAIL commit_we: got %0b expected %0b", rfile_we, mon_e.we);
                else
                    pass_cnt++;
                if (mon_e.we) begin
                    total_cnt++;
                    if ({cadr, c} !== {mon_e.adr, mon_e.data})
                        $display("[TB] FAIL commit_data: got cadr=%0d c=%h expected cadr=%0d c=%h",
                                 cadr, c, mon_e.adr, mon_e.data);
                    else
                        pass_cnt++;
                end
            end
        end
    end

    task automatic push_exp(input logic we, input logic [3:0] adr, input logic [15:0] data);
        wr_t e;
        e.we = we; e.adr = adr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_idle();
        alu_valid = 1'b0;
        ld_valid = 1'b0;
        wb_hold = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        set_idle();
        push_exp(1'b0, 4'd0, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu_valid = 1'b1; alu_adr = 4'd1; alu_data = 16'h1111;
        ld_valid = 1'b1;  ld_adr = 4'd2;  ld_data = 16'h2222;
        wb_hold = 1'b0; issue_valid = 1'b0; issue_adr = 4'd0;
        chk_aadr = 4'd0; chk_badr = 4'd0; chk_cadr = 4'd0;
        repeat (2) @(negedge clk);
        rf_clear = 1'b0;
        total_cnt++; if (rfile_we !== 1'b0) $display("[TB] FAIL reset_we: got %0b expected 0", rfile_we); else pass_cnt++;
        total_cnt++; if (cadr !== 4'd0) $display("[TB] FAIL reset_cadr: got %0d expected 0", cadr); else pass_cnt++;
        total_cnt++; if (c !== 16'h0) $display("[TB] FAIL reset_c: got %h expected 0000", c); else pass_cnt++;
        total_cnt++; if (hazard !== 1'b0) $display("[TB] FAIL reset_hazard: got %0b expected 0", hazard); else pass_cnt++;
        total_cnt++; if ({alu_ready, ld_ready} !== 2'b00)
            $display("[TB] FAIL reset_ready: got alu=%0b ld=%0b expected 0 0", alu_ready, ld_ready); else pass_cnt++;
        @(negedge clk);
        set_idle();
        rst = 1'b0;
        mon_en = 1'b1;
        push_exp(1'b0, 4'd0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        logic exp_alu;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_adr = 4'd5; alu_data = 16'hAAAA;
            ld_valid = 1'b1;  ld_adr = 4'd6;  ld_data = 16'h5555;
            #1;
            exp_alu = (i % 2 == 0);
            total_cnt++;
            if ({alu_ready, ld_ready} !== {exp_alu, ~exp_alu})
                $display("[TB] FAIL b2b_grant%0d: got alu=%0b ld=%0b expected alu=%0b ld=%0b",
                         i, alu_ready, ld_ready, exp_alu, ~exp_alu);
            else
                pass_cnt++;
            push_exp(1'b1, exp_alu ? 4'd5 : 4'd6, exp_alu ? 16'hAAAA : 16'h5555);
        end
        idle_cycle();
    endtask

    task automatic test_same_reg();
        @(negedge clk);
        alu_valid = 1'b1; alu_adr = 4'd7; alu_data = 16'h0001;
        ld_valid = 1'b1;  ld_adr = 4'd7;  ld_data = 16'h0002;
        #1;
        total_cnt++; if ({alu_ready, ld_ready} !== 2'b10)
            $display("[TB] FAIL same_reg_first: got alu=%0b ld=%0b expected 1 0", alu_ready, ld_ready); else pass_cnt++;
        push_exp(1'b1, 4'd7, 16'h0001);
        @(negedge clk);
        alu_valid = 1'b0;
        #1;
        total_cnt++; if ({alu_ready, ld_ready} !== 2'b01)
            $display("[TB] FAIL same_reg_second: got alu=%0b ld=%0b expected 0 1", alu_ready, ld_ready); else pass_cnt++;
        push_exp(1'b1, 4'd7, 16'h0002);
        idle_cycle();
        idle_cycle();
        total_cnt++; if (rf[7] !== 16'h0002) $display("[TB] FAIL same_reg_r7: got %h expected 0002", rf[7]); else pass_cnt++;
    endtask

    task automatic test_single();
        @(negedge clk);
        alu_valid = 1'b1; alu_adr = 4'd3; alu_data = 16'h1234;
        #1;
        total_cnt++; if ({alu_ready, ld_ready} !== 2'b10)
            $display("[TB] FAIL single_ready: got alu=%0b ld=%0b expected 1 0", alu_ready, ld_ready); else pass_cnt++;
        push_exp(1'b1, 4'd3, 16'h1234);
        idle_cycle();
        #1;
        total_cnt++; if (alu_ready !== 1'b0) $display("[TB] FAIL single_ready_drop: got %0b expected 0", alu_ready); else pass_cnt++;
        idle_cycle();
        total_cnt++; if (rf[3] !== 16'h1234) $display("[TB] FAIL single_r3: got %h expected 1234", rf[3]); else pass_cnt++;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb_hold = 1'b1;
            alu_valid = 1'b1; alu_adr = 4'd10; alu_data = 16'hBEEF;
            ld_valid = 1'b1;  ld_adr = 4'd11;  ld_data = 16'hCAFE;
            #1;
            total_cnt++; if ({alu_ready, ld_ready} !== 2'b00)
                $display("[TB] FAIL hold_ready%0d: got alu=%0b ld=%0b expected 0 0", i, alu_ready, ld_ready); else pass_cnt++;
            push_exp(1'b0, 4'd0, 16'h0000);
        end
        @(negedge clk);
        wb_hold = 1'b0;
        #1;
        total_cnt++; if ({alu_ready, ld_ready} !== 2'b01)
            $display("[TB] FAIL hold_release: got alu=%0b ld=%0b expected 0 1", alu_ready, ld_ready); else pass_cnt++;
        push_exp(1'b1, 4'd11, 16'hCAFE);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        total_cnt++; if ({alu_ready, ld_ready} !== 2'b10)
            $display("[TB] FAIL hold_after: got alu=%0b ld=%0b expected 1 0", alu_ready, ld_ready); else pass_cnt++;
        push_exp(1'b1, 4'd10, 16'hBEEF);
        idle_cycle();
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        alu_valid = 1'b1; alu_adr = 4'd12; alu_data = 16'h0F0F;
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("[TB] FAIL abort_ready: got %0b expected 1", alu_ready); else pass_cnt++;
        push_exp(1'b1, 4'd12, 16'h0F0F);
        @(negedge clk);
        set_idle();
        mon_en = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        total_cnt++; if (rfile_we !== 1'b0) $display("[TB] FAIL abort_we: got %0b expected 0", rfile_we); else pass_cnt++;
        total_cnt++; if (cadr !== 4'd0) $display("[TB] FAIL abort_cadr: got %0d expected 0", cadr); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++; if (rf[12] !== 16'h0000) $display("[TB] FAIL abort_r12: got %h expected 0000", rf[12]); else pass_cnt++;
        @(negedge clk);
        mon_en = 1'b1;
        alu_valid = 1'b1; alu_adr = 4'd13; alu_data = 16'h1313;
        ld_valid = 1'b1;  ld_adr = 4'd14;  ld_data = 16'h1414;
        #1;
        total_cnt++; if ({alu_ready, ld_ready} !== 2'b10)
            $display("[TB] FAIL abort_last_grant: got alu=%0b ld=%0b expected 1 0", alu_ready, ld_ready); else pass_cnt++;
        push_exp(1'b1, 4'd13, 16'h1313);
        idle_cycle();
    endtask

`ifdef RFILE_WB_SCOREBOARD_EN
    task automatic test_scoreboard();
        @(negedge clk);
        set_idle();
        issue_valid = 1'b1; issue_adr = 4'd9;
        chk_aadr = 4'd9; chk_badr = 4'd1; chk_cadr = 4'd2;
        push_exp(1'b0, 4'd0, 16'h0000);
        #1;
        total_cnt++; if (hazard !== 1'b0) $display("[TB] FAIL sb_before_issue: got %0b expected 0", hazard); else pass_cnt++;
        idle_cycle();
        #1;
        total_cnt++; if (hazard !== 1'b1) $display("[TB] FAIL sb_pending: got %0b expected 1", hazard); else pass_cnt++;
        @(negedge clk);
        alu_valid = 1'b1; alu_adr = 4'd9; alu_data = 16'h9999;
        #1;
        total_cnt++; if (alu_ready !== 1'b1) $display("[TB] FAIL sb_alu_ready: got %0b expected 1", alu_ready); else pass_cnt++;
        push_exp(1'b1, 4'd9, 16'h9999);
        idle_cycle();
        #1;
        total_cnt++; if (hazard !== 1'b1) $display("[TB] FAIL sb_commit_cycle: got %0b expected 1", hazard); else pass_cnt++;
        idle_cycle();
        #1;
        total_cnt++; if (hazard !== 1'b0) $display("[TB] FAIL sb_cleared: got %0b expected 0", hazard); else pass_cnt++;
        @(negedge clk);
        alu_valid = 1'b1; alu_adr = 4'd9; alu_data = 16'h7777;
        push_exp(1'b1, 4'd9, 16'h7777);
        @(negedge clk);
        set_idle();
        issue_valid = 1'b1; issue_adr = 4'd9;
        push_exp(1'b0, 4'd0, 16'h0000);
        idle_cycle();
        #1;
        total_cnt++; if (hazard !== 1'b1) $display("[TB] FAIL sb_set_wins: got %0b expected 1", hazard); else pass_cnt++;
    endtask
`else
    task automatic test_hazard_tied();
        @(negedge clk);
        set_idle();
        issue_valid = 1'b1; issue_adr = 4'd9;
        chk_aadr = 4'd9; chk_badr = 4'd9; chk_cadr = 4'd9;
        push_exp(1'b0, 4'd0, 16'h0000);
        idle_cycle();
        #1;
        total_cnt++; if (hazard !== 1'b0) $display("[TB] FAIL hazard_tied: got %0b expected 0", hazard); else pass_cnt++;
        idle_cycle();
        #1;
        total_cnt++; if (hazard !== 1'b0) $display("[TB] FAIL hazard_tied_late: got %0b expected 0", hazard); else pass_cnt++;
    endtask
`endif

    initial begin
        $display("[TB] starting rfile_wb_arbiter bench");
        test_reset();
        test_back_to_back();
        test_same_reg();
        test_single();
        test_hold();
        test_reset_abort();
`ifdef RFILE_WB_SCOREBOARD_EN
        test_scoreboard();
`else
        test_hazard_tied();
`endif
        idle_cycle();
        @(negedge clk);
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (exp_q.size() != 0) $display("[TB] FAIL queue_drain: got %0d entries left expected 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
